// File: rtl/alu_pkg.sv
// Shared ALU definitions for the iterative multiply/divide units.
// Holds the 6-bit function codes decoded from the ALU Signal input
// and the sequencing state type used by the iterative units.
package alu_pkg;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_OUT   = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath for seq_multiplier.
// Holds the multiplicand and the 2*WIDTH product/multiplier register,
// performs one conditional add-and-shift per step and, when
// SIGNED_MULT_EN is defined, the operand magnitude conversion and the
// final two's-complement negate.
// Ports:
//   clk, reset   clock, async active-high reset
//   load         capture operands, clear upper product half
//   step         one add-and-shift iteration
//   sgn, fix     (SIGNED_MULT_EN only) signed load / final negate
//   a, b         multiplicand, multiplier
//   prod         current product register contents
module mult_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
`ifdef SIGNED_MULT_EN
  input  logic               sgn,
  input  logic               fix,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod
);

  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

`ifdef SIGNED_MULT_EN
  logic neg_q;

  always_comb begin
    a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag = (sgn && b[WIDTH-1]) ? -b : b;
  end
`else
  always_comb begin
    a_mag = a;
    b_mag = b;
  end
`endif

  // The carry bit of {carry,upper,lower} is always zero between steps, so it
  // only exists as the top bit of this WIDTH+1 sum before the shift.
  always_comb begin
    sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0])
      sum = sum + {1'b0, mcand_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q  <= '0;
      mcand_q <= '0;
`ifdef SIGNED_MULT_EN
      neg_q   <= 1'b0;
`endif
    end else if (load) begin
      mcand_q <= a_mag;
      prod_q  <= {{WIDTH{1'b0}}, b_mag};
`ifdef SIGNED_MULT_EN
      neg_q   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
    end else if (step) begin
      prod_q  <= {sum, prod_q[WIDTH-1:1]};
`ifdef SIGNED_MULT_EN
    end else if (fix) begin
      if (neg_q)
        prod_q <= -prod_q;
`endif
    end
  end

  assign prod = prod_q;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier driven by the ALU function code.
// MULTU (edge-detected) starts a WIDTH-cycle multiply; OUT copies the
// finished product to dataOut when not running.
// Optional feature macro: SIGNED_MULT_EN adds MULT (signed) with one
// extra fix-up cycle.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   dataA    multiplicand
//   dataB    multiplier
//   Signal   6-bit function code
//   dataOut  product {HI,LO}, updated by OUT only
//   busy     high while iterating
//   done     high from completion until next start or reset
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [5:0]         Signal,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [5:0]         sig_q;
  logic               start;
  logic               load;
  logic               step;
  logic [2*WIDTH-1:0] prod;

`ifdef SIGNED_MULT_EN
  localparam logic [CNT_W-1:0] FIXC = CNT_W'(WIDTH);
  logic start_s;
  logic signed_q;
  logic fix;

  assign start_s = (Signal == FN_MULT) && (sig_q != FN_MULT);
  assign start   = ((Signal == FN_MULTU) && (sig_q != FN_MULTU)) || start_s;
`else
  assign start   = (Signal == FN_MULTU) && (sig_q != FN_MULTU);
`endif

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
`ifdef SIGNED_MULT_EN
    fix     = 1'b0;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
`ifdef SIGNED_MULT_EN
        // Signed ops run one extra cycle (cnt==WIDTH) for the negate.
        if (signed_q && cnt == FIXC) begin
          fix     = 1'b1;
          state_n = DONE;
        end else begin
          step = 1'b1;
          if (!signed_q && cnt == LAST)
            state_n = DONE;
        end
`else
        step = 1'b1;
        if (cnt == LAST)
          state_n = DONE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sig_q   <= '0;
      dataOut <= '0;
`ifdef SIGNED_MULT_EN
      signed_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sig_q <= Signal;
      if (load)
        cnt <= '0;
      else if (step)
        cnt <= cnt + 1'b1;
`ifdef SIGNED_MULT_EN
      if (load)
        signed_q <= start_s;
`endif
      if (Signal == FN_OUT && state != RUN)
        dataOut <= prod;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  mult_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
`ifdef SIGNED_MULT_EN
    .sgn   (start_s),
    .fix   (fix),
`endif
    .a     (dataA),
    .b     (dataB),
    .prod  (prod)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = '0;
  logic [63:0] dataOut;
  logic        busy;
  logic        done;

  int compared = 0;
  int mismatched = 0;
  int cyc;

  seq_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] code);
    dataA  = a;
    dataB  = b;
    Signal = code;
    tick();
    Signal = 6'b000000;
  endtask

  // Counts edges after the start edge until done, bounded at 100.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic do_out();
    Signal = FN_OUT;
    tick();
    Signal = 6'b000000;
  endtask

  initial begin
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", dataOut, 0);
    reset = 1'b0;
    tick();
    do_out();
    check("out_after_rst", dataOut, 0);

    // 3 * 5
    start_op(32'd3, 32'd5, FN_MULTU);
    check("t1_busy", busy, 1);
    wait_done(cyc);
    check("t1_latency", 64'(cyc), 64'd32);
    check("t1_busy_end", busy, 0);
    do_out();
    check("t1_prod", dataOut, 64'h0000_0000_0000_000F);

    // carry exercise
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, FN_MULTU);
    wait_done(cyc);
    do_out();
    check("t2_ff", dataOut, 64'hFFFF_FFFE_0000_0001);
    do_out();
    check("t2_repeat_out", dataOut, 64'hFFFF_FFFE_0000_0001);
    start_op(32'h8000_0000, 32'd2, FN_MULTU);
    wait_done(cyc);
    do_out();
    check("t2_msb", dataOut, 64'h0000_0001_0000_0000);

    // MULTU held 40 cycles: single operation only
    dataA  = 32'd7;
    dataB  = 32'd0;
    Signal = FN_MULTU;
    for (int i = 0; i < 40; i++) tick();
    check("t3_hold_done", done, 1);
    check("t3_hold_busy", busy, 0);
    Signal = 6'b000000;
    tick();
    do_out();
    check("t3_hold_prod", dataOut, 0);

    // second MULTU edge during RUN is ignored
    start_op(32'd7, 32'd3, FN_MULTU);
    for (int i = 0; i < 4; i++) tick();
    start_op(32'd9, 32'd9, FN_MULTU);
    check("t3_still_busy", busy, 1);
    wait_done(cyc);
    check("t3_latency", 64'(cyc + 5), 64'd32);
    do_out();
    check("t3_prod", dataOut, 64'd21);

    // OUT during RUN is ignored
    start_op(32'd100, 32'd200, FN_MULTU);
    for (int i = 0; i < 9; i++) tick();
    do_out();
    check("t4_out_in_run", dataOut, 64'd21);
    wait_done(cyc);
    check("t4_latency", 64'(cyc + 10), 64'd32);
    do_out();
    check("t4_prod", dataOut, 64'd20000);

    // async reset mid-RUN
    start_op(32'd5, 32'd5, FN_MULTU);
    for (int i = 0; i < 14; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_out", dataOut, 0);
    tick();
    reset = 1'b0;
    tick();
    do_out();
    check("t5_out_after", dataOut, 0);

`ifdef SIGNED_MULT_EN
    start_op(32'hFFFF_FFFD, 32'd5, FN_MULT);
    wait_done(cyc);
    check("t6_latency", 64'(cyc), 64'd33);
    do_out();
    check("t6_prod", dataOut, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    start_op(32'hFFFF_FFFD, 32'd5, FN_MULT);
    check("t6_busy", busy, 0);
    tick();
    check("t6_done", done, 0);
    check("t6_out", dataOut, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
